// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and helpers for the TDM mux/demux pair
package tdm_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tdm_state_t;

    // Counter width that never collapses to zero bits for tiny parameters.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial line inputs and per-channel outputs of the TDM demux
interface tdm_demux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    logic                       tdm_en;
    logic                       tdm_sync;
    logic                       tdm_din;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [NUM_CH-1:0]          ch_valid;
    logic                       frame_err;
    logic                       in_frame;

    modport master (
        output tdm_en, tdm_sync, tdm_din,
        input  ch_data, ch_valid, frame_err, in_frame
    );

    modport slave (
        input  tdm_en, tdm_sync, tdm_din,
        output ch_data, ch_valid, frame_err, in_frame
    );
endinterface

// File: rtl/tdm_bit_deser.sv
// rtl/tdm_bit_deser.sv - MSB-first slot shift register with bit counter
module tdm_bit_deser
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8,
    localparam int BW = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              restart,
    input  logic              din,
    output logic [DATA_W-1:0] word,
    output logic              word_done,
    output logic [BW-1:0]     bit_cnt
);

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     cnt;

    // The word includes the bit on the line now so the owner can latch it on this edge.
    assign word      = {shreg[DATA_W-2:0], din};
    assign word_done = shift_en && !restart && (cnt == LAST_BIT);
    assign bit_cnt   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift_en) begin
            if (restart) begin
                shreg <= {{(DATA_W-1){1'b0}}, din};
                cnt   <= BW'(1);
            end else begin
                shreg <= word;
                cnt   <= (cnt == LAST_BIT) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - 1-bit TDM line to NUM_CH parallel channel words
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus
);

    localparam int SW = cnt_w(NUM_CH);
    localparam int BW = cnt_w(DATA_W);

    localparam logic [0:0]    ST_IDLE   = 1'(IDLE);
    localparam logic [0:0]    ST_RUN    = 1'(RUN);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

    logic [0:0]               state, state_nxt;
    logic [SW-1:0]            slot, slot_nxt;
    logic                     shift_en, restart, load, err_nxt, at_start;
    logic [DATA_W-1:0]        word;
    logic                     word_done;
    logic [BW-1:0]            bit_cnt;
    logic [NUM_CH*DATA_W-1:0] ch_data_q;
    logic [NUM_CH-1:0]        ch_valid_q;
    logic                     frame_err_q;

    tdm_bit_deser #(.DATA_W(DATA_W)) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (shift_en),
        .restart   (restart),
        .din       (bus.tdm_din),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    assign at_start = (bit_cnt == '0) && (slot == '0);

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        shift_en  = 1'b0;
        restart   = 1'b0;
        load      = 1'b0;
        err_nxt   = 1'b0;
        if (bus.tdm_en) begin
            if (state == ST_IDLE) begin
                if (bus.tdm_sync) begin
                    shift_en  = 1'b1;
                    restart   = 1'b1;
                    slot_nxt  = '0;
                    state_nxt = ST_RUN;
                end
            end else if (bus.tdm_sync) begin
                // Sync always restarts slot 0; it is only an error when it arrives early.
                shift_en = 1'b1;
                restart  = 1'b1;
                slot_nxt = '0;
                err_nxt  = !at_start;
            end else if (at_start) begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                shift_en = 1'b1;
                if (word_done) begin
                    load     = 1'b1;
                    slot_nxt = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            slot        <= '0;
            ch_data_q   <= '0;
            ch_valid_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            frame_err_q <= err_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_valid_q[c] <= load && (slot == SW'(c));
                if (load && (slot == SW'(c)))
                    ch_data_q[c*DATA_W +: DATA_W] <= word;
            end
        end
    end

    assign bus.ch_data   = ch_data_q;
    assign bus.ch_valid  = ch_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.in_frame  = (state == ST_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for the TDM demux
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t vq[$];
    int   eq[$];
    logic [31:0] exp_data;
    logic [7:0]  nw0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tdm_demux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.ch_valid !== '0) begin
            check("valid_onehot", 64'($onehot(bus.ch_valid)), 64'd1);
            check("valid_err_excl", 64'(bus.frame_err), 64'd0);
            if (vq.size() == 0) begin
                check("unexp_valid", 64'(bus.ch_valid), 64'd0);
            end else begin
                e = vq.pop_front();
                check("valid_ch", 64'(bus.ch_valid), 64'(4'b0001 << e.ch));
                check("valid_data", 64'(bus.ch_data[e.ch*8 +: 8]), 64'(e.data));
                check("valid_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
        if (bus.frame_err === 1'b1) begin
            if (eq.size() == 0) check("unexp_err", 64'd1, 64'd0);
            else                check("err_cyc", 64'(cyc), 64'(eq.pop_front()));
        end
    end

    task automatic beat(input logic s, input logic d);
        @(posedge clk);
        #1;
        bus.tdm_en   = 1'b1;
        bus.tdm_sync = s;
        bus.tdm_din  = d;
    endtask

    // Gap cycles carry random sync/data to show they are ignored without tdm_en.
    task automatic idle();
        @(posedge clk);
        #1;
        bus.tdm_en   = 1'b0;
        bus.tdm_sync = 1'($urandom);
        bus.tdm_din  = 1'($urandom);
    endtask

    task automatic send_word(input logic [7:0] w, input int slot, input logic sync_first,
                             input int gap, input int top_bit);
        for (int i = top_bit; i >= 0; i--) begin
            beat(sync_first && (i == 7), w[i]);
            if (i == 0) begin
                vq.push_back('{slot, w, cyc + 1});
                exp_data[slot*8 +: 8] = w;
            end
            for (int g = 0; g < gap; g++) idle();
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap);
        for (int s = 0; s < NUM_CH; s++)
            send_word(f[s*8 +: 8], s, s == 0, gap, 7);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.tdm_en   = 1'b0;
        bus.tdm_sync = 1'b0;
        bus.tdm_din  = 1'b0;
        exp_data     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ch_data", 64'(bus.ch_data), 64'd0);
        check("rst_ch_valid", 64'(bus.ch_valid), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_in_frame", 64'(bus.in_frame), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsynced beats in IDLE are dropped silently.
        for (int i = 0; i < 5; i++) beat(1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("idle_in_frame", 64'(bus.in_frame), 64'd0);

        send_frame(32'h01FF3CA5, 0);
        idle();
        @(negedge clk);
        check("f1_data", 64'(bus.ch_data), 64'h01FF3CA5);
        check("f1_in_frame", 64'(bus.in_frame), 64'd1);

        send_frame(32'h01FF3CA5, 1);
        idle();
        @(negedge clk);
        check("gap_data", 64'(bus.ch_data), 64'h01FF3CA5);

        send_frame(32'h44332211, 0);
        send_frame(32'h88776655, 0);
        idle();
        @(negedge clk);
        check("b2b_data", 64'(bus.ch_data), 64'h88776655);

        // Early sync at bit 3 of slot 1.
        send_word(8'h5A, 0, 1'b1, 0, 7);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b1);
        nw0 = 8'hEF;
        beat(1'b1, nw0[7]);
        eq.push_back(cyc + 1);
        beat(1'b0, nw0[6]);
        @(negedge clk);
        check("esync_slot0_kept", 64'(bus.ch_data[7:0]), 64'h5A);
        check("esync_slot1_kept", 64'(bus.ch_data[15:8]), 64'h66);
        check("esync_in_frame", 64'(bus.in_frame), 64'd1);
        send_word(nw0, 0, 1'b0, 0, 5);
        send_word(8'hBE, 1, 1'b0, 0, 7);
        send_word(8'hAD, 2, 1'b0, 0, 7);
        send_word(8'hDE, 3, 1'b0, 0, 7);
        idle();
        @(negedge clk);
        check("esync_new_frame", 64'(bus.ch_data), 64'hDEADBEEF);

        // Missing sync after a complete frame.
        beat(1'b0, 1'b1);
        eq.push_back(cyc + 1);
        beat(1'b0, 1'b0);
        @(negedge clk);
        check("nosync_in_frame", 64'(bus.in_frame), 64'd0);
        for (int i = 0; i < 20; i++) beat(1'b0, 1'($urandom));
        idle();
        @(negedge clk);
        check("nosync_idle", 64'(bus.in_frame), 64'd0);
        check("nosync_data", 64'(bus.ch_data), 64'(exp_data));

        // Reset in the middle of slot 2.
        send_word(8'h12, 0, 1'b1, 0, 7);
        send_word(8'h34, 1, 1'b0, 0, 7);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ch_data", 64'(bus.ch_data), 64'd0);
        check("mrst_ch_valid", 64'(bus.ch_valid), 64'd0);
        check("mrst_frame_err", 64'(bus.frame_err), 64'd0);
        check("mrst_in_frame", 64'(bus.in_frame), 64'd0);
        bus.tdm_en = 1'b0;
        exp_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(32'hCAFEF00D, 0);
        idle();
        @(negedge clk);
        check("post_rst_data", 64'(bus.ch_data), 64'hCAFEF00D);
        check("model_data", 64'(bus.ch_data), 64'(exp_data));

        repeat (4) idle();
        check("vq_empty", 64'(vq.size()), 64'd0);
        check("eq_empty", 64'(eq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
